vga_fb_scheduler: RTL and testbench
===================================

Name: vga_fb_scheduler

Overview:
- Arbitrates one single-port framebuffer RAM between two users: VGA line prefetch and host pixel writes.
- At the start of each horizontal blank it fetches the next display line into a ping-pong line buffer. Host writes are served whenever no fetch is running.
- Sits between hvsync_generator (pix_clk domain) and the framebuffer RAM/line buffer. Drives the RAM port and the line-buffer write port.

Parameters:
- H_ACTIVE, 640, visible pixels per line; fetch trigger is h_count == H_ACTIVE.
- V_ACTIVE, 480, visible lines.
- V_TOTAL, 525, total lines per frame, including blanking.
- PIX_PER_WORD, 8, pixels per RAM word.
- DATA_W, 24, RAM word width (3 bits RGB per pixel).
- ADDR_W, 16, RAM word-address width.

Ports:
- clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- h_count  in  10  from sync generator.
- v_count  in  10  from sync generator.
- host_req  in  1  write request; held until host_ack.
- host_addr  in  ADDR_W  word address.
- host_wdata  in  DATA_W  write data.
- host_ack  out  1  one-cycle pulse when the write is issued.
- mem_en  out  1  RAM enable.
- mem_we  out  1  RAM write enable.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid 1 cycle after mem_en with mem_we=0.
- lb_we  out  1  line-buffer write strobe.
- lb_bank  out  1  target bank = fetched display line[0].
- lb_addr  out  7  word index within the line.
- lb_wdata  out  DATA_W  = mem_rdata.
- fetch_busy  out  1  high while state is FETCH or the drain cycle is pending.
- fetch_overrun  out  1  sticky error flag.

Behaviour:
- Reset is synchronous, active-high, on clk.
- Reset values: every output 0, state IDLE, word counter 0, overrun flag 0.
- Reset mid-operation aborts a fetch or host write at once. lb_we is 0 from the next cycle and any in-flight read data is discarded.
- WORDS = H_ACTIVE/PIX_PER_WORD = 80.
- next_line = (v_count == V_TOTAL-1) ? 0 : v_count+1. Wrap-around at V_TOTAL-1 fetches line 0.
- trigger = (h_count == H_ACTIVE) && (next_line < V_ACTIVE), evaluated every cycle.
- State IDLE:
  - trigger → FETCH. Latch line = next_line; base = line*80, computed as (line<<6)+(line<<4) in ADDR_W bits; counter i = 0.
  - else host_req → HOST.
  - Trigger beats host_req when both arrive in the same cycle.
- State FETCH:
  - Each cycle: mem_en=1, mem_we=0, mem_addr = base+i, i++.
  - After i = 79 is issued → IDLE.
  - A request issued in cycle T produces lb_we=1, lb_addr=i, lb_wdata=mem_rdata, lb_bank=line[0] in cycle T+1.
  - Trigger arrives at cycle C: mem_en high C+1..C+80; lb_we high C+2..C+81.
  - fetch_busy high C+1..C+81.
  - The fetch completes well inside the 160-cycle blank.
- State HOST (exactly 1 cycle):
  - mem_en=1, mem_we=1, mem_addr=host_addr, mem_wdata=host_wdata, host_ack=1 → IDLE.
  - Host write latency is 1 cycle from sampled request to ack.
  - A host request pending during FETCH waits; the earliest ack is the cycle after FETCH exits.
- Trigger while already in FETCH: fetch_overrun ← 1, the trigger is ignored, and the current fetch continues. The flag clears only on reset.
- While idle, mem_addr and mem_wdata hold their last value with mem_en=0.
- A back-to-back host_req held high gives one write every 2 cycles: HOST, IDLE, HOST.

Optional Feature:
- Macro: VGA_FB_SCROLL_EN.
- Defined:
  - Adds input scroll_y [9:0], which must be < V_ACTIVE.
  - Fetched line = next_line + scroll_y, minus V_ACTIVE if the sum ≥ V_ACTIVE.
  - The result is registered into line when the trigger fires. lb_bank still uses next_line[0].
  - scroll_y is sampled only on trigger.
- Undefined: no scroll_y port; fetched line = next_line.

Decomposition:
- Package vga_fb_pkg holds:
  - WORDS_PER_LINE and LB_ADDR_W localparams.
  - The state enum typedef (IDLE, FETCH, HOST).
  - The line-to-base address function (line*80 via shifts).
- No sub-module; all logic stays in vga_fb_scheduler.

Test Plan:
- Set h_count=640, v_count=9 → mem_addr runs 800..879 on consecutive cycles; lb_we for 80 cycles with lb_addr 0..79; lb_bank=0.
- Set v_count=524 at h_count=640 → line 0 fetched, addresses 0..79. With v_count=479..523 there is no fetch and mem_en stays 0.
- Assert host_req with addr 0x1234, data 0xABCDEF, while idle → one cycle later mem_we=1, mem_addr=0x1234, host_ack=1; next cycle idle.
- Assert host_req in the same cycle as the trigger → fetch runs first; host_ack occurs exactly 1 cycle after the last fetch mem_en.
- Force a second trigger during a fetch → fetch_overrun=1 and stays set; the 80-word sequence is undisturbed. Assert reset for 1 cycle at fetch word 40 → lb_we=0 and fetch_overrun=0 on the next cycle.
- With VGA_FB_SCROLL_EN, scroll_y=470 and v_count=19 → fetched line 10, addresses 800..879, lb_bank=0.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// -----------------------------------------------------------------------------
// vga_fb_pkg
// Shared definitions for the VGA framebuffer scheduler:
//   WORDS_PER_LINE  RAM words per visible line (640 px / 8 px per word)
//   LB_ADDR_W       width of a word index within one line
//   state_t         scheduler FSM states
//   line_base()     word address of the first word of a display line
// -----------------------------------------------------------------------------
package vga_fb_pkg;

   localparam int WORDS_PER_LINE = 80;
   localparam int LB_ADDR_W      = 7;

   typedef enum logic [1:0] {
      IDLE,
      FETCH,
      HOST
   } state_t;

   // line * 80 built from two shifts so no multiplier is inferred.
   // 17 bits hold the largest product of a 10-bit line number.
   function automatic logic [16:0] line_base(input logic [9:0] line);
      logic [16:0] l;
      l = {7'd0, line};
      return (l << 6) + (l << 4);
   endfunction

endpackage

// File: rtl/vga_fb_scheduler.sv
// -----------------------------------------------------------------------------
// vga_fb_scheduler
// Shares one single-port framebuffer RAM between VGA line prefetch and host
// pixel writes. When h_count reaches the end of the visible area, the next
// display line is read word by word into a ping-pong line buffer; host writes
// are issued whenever no fetch is running.
//
// Ports:
//   clk, reset             pixel clock; synchronous active-high reset
//   h_count, v_count       beam position from the sync generator
//   host_req/addr/wdata    host write request (held until host_ack)
//   host_ack               one-cycle pulse when the write is on the RAM port
//   mem_en/we/addr/wdata   RAM port (registered)
//   mem_rdata              RAM read data, valid one cycle after a read
//   lb_we/bank/addr/wdata  line-buffer write port
//   fetch_busy             fetch running or its last read still draining
//   fetch_overrun          sticky: a trigger arrived while a fetch was running
//   scroll_y               only with VGA_FB_SCROLL_EN: vertical scroll offset
//
// Build option: define VGA_FB_SCROLL_EN to add the scroll_y input.
// -----------------------------------------------------------------------------
module vga_fb_scheduler
   import vga_fb_pkg::*;
#(
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 480,
   parameter int V_TOTAL      = 525,
   parameter int PIX_PER_WORD = 8,
   parameter int DATA_W       = 24,
   parameter int ADDR_W       = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [9:0]           h_count,
   input  logic [9:0]           v_count,
`ifdef VGA_FB_SCROLL_EN
   input  logic [9:0]           scroll_y,
`endif
   input  logic                 host_req,
   input  logic [ADDR_W-1:0]    host_addr,
   input  logic [DATA_W-1:0]    host_wdata,
   output logic                 host_ack,
   output logic                 mem_en,
   output logic                 mem_we,
   output logic [ADDR_W-1:0]    mem_addr,
   output logic [DATA_W-1:0]    mem_wdata,
   input  logic [DATA_W-1:0]    mem_rdata,
   output logic                 lb_we,
   output logic                 lb_bank,
   output logic [LB_ADDR_W-1:0] lb_addr,
   output logic [DATA_W-1:0]    lb_wdata,
   output logic                 fetch_busy,
   output logic                 fetch_overrun
);

   localparam int WORDS = H_ACTIVE / PIX_PER_WORD;

   state_t               state;
   logic [LB_ADDR_W-1:0] word_cnt;    // next word index to issue
   logic [LB_ADDR_W-1:0] rd_idx;      // word index currently on mem_addr
   logic [ADDR_W-1:0]    fetch_base;
   logic                 line_bank;

   logic [9:0]           next_line;
   logic [9:0]           fetch_line;
   logic [ADDR_W-1:0]    start_base;
   logic                 trigger;

   assign next_line = (v_count == 10'(V_TOTAL - 1)) ? 10'd0 : v_count + 10'd1;
   assign trigger   = (h_count == 10'(H_ACTIVE)) && (next_line < 10'(V_ACTIVE));

`ifdef VGA_FB_SCROLL_EN
   logic [10:0] scroll_sum;
   assign scroll_sum = {1'b0, next_line} + {1'b0, scroll_y};
`endif

   // NOTE: every variable written in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      fetch_line = next_line;
`ifdef VGA_FB_SCROLL_EN
      if (scroll_sum >= 11'(V_ACTIVE))
         fetch_line = 10'(scroll_sum - 11'(V_ACTIVE));
      else
         fetch_line = scroll_sum[9:0];
`endif
      start_base = ADDR_W'(line_base(fetch_line));
   end

   // Line data arrives straight from the RAM; lb_we/lb_addr are delayed one
   // cycle to line up with it.
   assign lb_wdata = mem_rdata;

   // Busy covers the issuing cycles plus the read-latency tail: the last read
   // is on the bus after the FSM has left FETCH, and its data is written to
   // the line buffer one cycle later.
   assign fetch_busy = (state == FETCH) || (mem_en && !mem_we) || lb_we;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         word_cnt      <= '0;
         rd_idx        <= '0;
         fetch_base    <= '0;
         line_bank     <= 1'b0;
         host_ack      <= 1'b0;
         mem_en        <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         lb_we         <= 1'b0;
         lb_bank       <= 1'b0;
         lb_addr       <= '0;
         fetch_overrun <= 1'b0;
      end else begin
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         host_ack <= 1'b0;
         lb_we    <= mem_en && !mem_we;
         lb_addr  <= rd_idx;
         lb_bank  <= line_bank;

         case (state)
            // A trigger is also honoured in HOST so the one-cycle h_count
            // window is never lost behind a host write.
            IDLE, HOST: begin
               if (trigger) begin
                  state      <= FETCH;
                  fetch_base <= start_base;
                  line_bank  <= next_line[0];
                  mem_en     <= 1'b1;
                  mem_addr   <= start_base;
                  rd_idx     <= '0;
                  word_cnt   <= LB_ADDR_W'(1);
               end else if (state == IDLE && host_req) begin
                  state     <= HOST;
                  mem_en    <= 1'b1;
                  mem_we    <= 1'b1;
                  mem_addr  <= host_addr;
                  mem_wdata <= host_wdata;
                  host_ack  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end

            FETCH: begin
               if (trigger)
                  fetch_overrun <= 1'b1;
               mem_en   <= 1'b1;
               mem_addr <= fetch_base + ADDR_W'(word_cnt);
               rd_idx   <= word_cnt;
               word_cnt <= word_cnt + LB_ADDR_W'(1);
               // Leaving FETCH as the last word is issued lets a waiting host
               // write follow immediately after the final read.
               if (word_cnt == LB_ADDR_W'(WORDS - 1))
                  state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// -----------------------------------------------------------------------------
// tb_vga_fb_scheduler
// Directed bench for vga_fb_scheduler: a table of single-cycle reactions from
// idle, followed by hand-written multi-cycle sequences (full line fetch,
// wrap-around, host/trigger collision, back-to-back host writes, overrun and
// mid-fetch reset). Define VGA_FB_SCROLL_EN to also exercise scroll_y.
// -----------------------------------------------------------------------------
module tb_vga_fb_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  h_count;
   logic [9:0]  v_count;
`ifdef VGA_FB_SCROLL_EN
   logic [9:0]  scroll_y;
`endif
   logic        host_req;
   logic [15:0] host_addr;
   logic [23:0] host_wdata;
   logic        host_ack;
   logic        mem_en;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [23:0] mem_wdata;
   logic [23:0] mem_rdata = '0;
   logic        lb_we;
   logic        lb_bank;
   logic [6:0]  lb_addr;
   logic [23:0] lb_wdata;
   logic        fetch_busy;
   logic        fetch_overrun;

   int n_tests = 0;
   int n_fail  = 0;

   vga_fb_scheduler dut (
      .clk          (clk),
      .reset        (reset),
      .h_count      (h_count),
      .v_count      (v_count),
`ifdef VGA_FB_SCROLL_EN
      .scroll_y     (scroll_y),
`endif
      .host_req     (host_req),
      .host_addr    (host_addr),
      .host_wdata   (host_wdata),
      .host_ack     (host_ack),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .lb_we        (lb_we),
      .lb_bank      (lb_bank),
      .lb_addr      (lb_addr),
      .lb_wdata     (lb_wdata),
      .fetch_busy   (fetch_busy),
      .fetch_overrun(fetch_overrun)
   );

   always #5 clk = ~clk;

   // RAM model: each read returns a tag plus the word address one cycle later.
   always @(posedge clk)
      if (mem_en && !mem_we)
         mem_rdata <= {8'hA5, mem_addr};

   typedef struct {
      string       name;
      logic [9:0]  h;
      logic [9:0]  v;
      logic        req;
      logic [15:0] addr;
      logic [23:0] wdata;
      logic        e_en;
      logic        e_we;
      logic        e_ack;
      logic        e_busy;
      logic [15:0] e_addr;
      logic [23:0] e_wdata;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge.
   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      h_count    = 10'd0;
      v_count    = 10'd0;
      host_req   = 1'b0;
      host_addr  = 16'h0;
      host_wdata = 24'h0;
`ifdef VGA_FB_SCROLL_EN
      scroll_y   = 10'd0;
`endif
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b1;
      step();
      reset = 1'b0;
   endtask

   // Trigger one fetch from idle and check every cycle of it (k = cycles
   // after the trigger cycle).
   task automatic run_fetch(input logic [9:0] v, input int base, input logic bank, input string tag);
      h_count = 10'd640;
      v_count = v;
      step();
      h_count = 10'd0;
      for (int k = 1; k <= 82; k++) begin
         check($sformatf("%s mem_en k=%0d", tag, k), 32'(mem_en), 32'(k <= 80));
         if (k <= 80) begin
            check($sformatf("%s mem_we k=%0d", tag, k), 32'(mem_we), 32'd0);
            check($sformatf("%s mem_addr k=%0d", tag, k), 32'(mem_addr), 32'(base + k - 1));
         end
         check($sformatf("%s lb_we k=%0d", tag, k), 32'(lb_we), 32'(k >= 2 && k <= 81));
         if (k >= 2 && k <= 81) begin
            check($sformatf("%s lb_addr k=%0d", tag, k), 32'(lb_addr), 32'(k - 2));
            check($sformatf("%s lb_bank k=%0d", tag, k), 32'(lb_bank), 32'(bank));
            check($sformatf("%s lb_wdata k=%0d", tag, k), 32'(lb_wdata),
                  32'({8'hA5, 16'(base + k - 2)}));
         end
         check($sformatf("%s busy k=%0d", tag, k), 32'(fetch_busy), 32'(k <= 81));
         step();
      end
   endtask

   initial begin
      int ack_k;
      int last_rd;

      vecs[0] = '{"trig v9",      10'd640, 10'd9,   1'b0, 16'h0,    24'h0,      1'b1, 1'b0, 1'b0, 1'b1, 16'd800,   24'h0};
      vecs[1] = '{"trig wrap",    10'd640, 10'd524, 1'b0, 16'h0,    24'h0,      1'b1, 1'b0, 1'b0, 1'b1, 16'd0,     24'h0};
      vecs[2] = '{"no trig v479", 10'd640, 10'd479, 1'b0, 16'h0,    24'h0,      1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     24'h0};
      vecs[3] = '{"no trig v523", 10'd640, 10'd523, 1'b0, 16'h0,    24'h0,      1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     24'h0};
      vecs[4] = '{"no trig h639", 10'd639, 10'd9,   1'b0, 16'h0,    24'h0,      1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     24'h0};
      vecs[5] = '{"no trig h641", 10'd641, 10'd9,   1'b0, 16'h0,    24'h0,      1'b0, 1'b0, 1'b0, 1'b0, 16'd0,     24'h0};
      vecs[6] = '{"trig v478",    10'd640, 10'd478, 1'b0, 16'h0,    24'h0,      1'b1, 1'b0, 1'b0, 1'b1, 16'd38320, 24'h0};
      vecs[7] = '{"host write",   10'd0,   10'd0,   1'b1, 16'h1234, 24'hABCDEF, 1'b1, 1'b1, 1'b1, 1'b0, 16'h1234,  24'hABCDEF};
      vecs[8] = '{"trig+host",    10'd640, 10'd9,   1'b1, 16'h1234, 24'hABCDEF, 1'b1, 1'b0, 1'b0, 1'b1, 16'd800,   24'h0};
      vecs[9] = '{"trig v0",      10'd640, 10'd0,   1'b0, 16'h0,    24'h0,      1'b1, 1'b0, 1'b0, 1'b1, 16'd80,    24'h0};

      // Reset state
      idle_inputs();
      reset = 1'b1;
      step();
      step();
      check("rst mem_en", 32'(mem_en), 32'd0);
      check("rst mem_we", 32'(mem_we), 32'd0);
      check("rst mem_addr", 32'(mem_addr), 32'd0);
      check("rst mem_wdata", 32'(mem_wdata), 32'd0);
      check("rst host_ack", 32'(host_ack), 32'd0);
      check("rst lb_we", 32'(lb_we), 32'd0);
      check("rst lb_bank", 32'(lb_bank), 32'd0);
      check("rst lb_addr", 32'(lb_addr), 32'd0);
      check("rst busy", 32'(fetch_busy), 32'd0);
      check("rst overrun", 32'(fetch_overrun), 32'd0);
      reset = 1'b0;
      step();

      // Table: one cycle of stimulus from idle, check the registered response
      foreach (vecs[i]) begin
         do_reset();
         h_count    = vecs[i].h;
         v_count    = vecs[i].v;
         host_req   = vecs[i].req;
         host_addr  = vecs[i].addr;
         host_wdata = vecs[i].wdata;
         step();
         idle_inputs();
         check({vecs[i].name, " mem_en"},    32'(mem_en),     32'(vecs[i].e_en));
         check({vecs[i].name, " mem_we"},    32'(mem_we),     32'(vecs[i].e_we));
         check({vecs[i].name, " host_ack"},  32'(host_ack),   32'(vecs[i].e_ack));
         check({vecs[i].name, " busy"},      32'(fetch_busy), 32'(vecs[i].e_busy));
         check({vecs[i].name, " mem_addr"},  32'(mem_addr),   32'(vecs[i].e_addr));
         check({vecs[i].name, " mem_wdata"}, 32'(mem_wdata),  32'(vecs[i].e_wdata));
      end

      // Full line fetches: line 10 (bank 0), wrap to line 0, line 11 (bank 1)
      do_reset();
      run_fetch(10'd9, 800, 1'b0, "fetch v9");
      run_fetch(10'd524, 0, 1'b0, "fetch wrap");
      run_fetch(10'd10, 880, 1'b1, "fetch v10");

      // Host write after idle returns to idle when the request is dropped
      do_reset();
      host_req = 1'b1; host_addr = 16'h1234; host_wdata = 24'hABCDEF;
      step();
      check("host ack", 32'(host_ack), 32'd1);
      host_req = 1'b0;
      step();
      check("host after ack en", 32'(mem_en), 32'd0);
      check("host after ack ack", 32'(host_ack), 32'd0);
      check("host hold addr", 32'(mem_addr), 32'h1234);

      // Trigger and host request in the same cycle: fetch first, then write
      do_reset();
      h_count = 10'd640; v_count = 10'd9;
      host_req = 1'b1; host_addr = 16'h1234; host_wdata = 24'hABCDEF;
      step();
      h_count = 10'd0;
      ack_k = -1;
      last_rd = -1;
      for (int k = 1; k <= 200; k++) begin
         if (mem_en && !mem_we) last_rd = k;
         if (host_ack) begin
            ack_k = k;
            break;
         end
         step();
      end
      check("collide last read", 32'(last_rd), 32'd80);
      check("collide ack cycle", 32'(ack_k), 32'd81);
      check("collide ack we", 32'(mem_we), 32'd1);
      check("collide ack addr", 32'(mem_addr), 32'h1234);
      check("collide ack wdata", 32'(mem_wdata), 32'hABCDEF);
      host_req = 1'b0;
      step();
      check("collide after ack", 32'(host_ack), 32'd0);

      // Back-to-back host requests: one write every two cycles
      do_reset();
      host_req = 1'b1; host_addr = 16'h0042; host_wdata = 24'h123456;
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("b2b ack k=%0d", k), 32'(host_ack), 32'(k % 2));
         check($sformatf("b2b en k=%0d", k), 32'(mem_en), 32'(k % 2));
      end
      host_req = 1'b0;

      // Second trigger during a fetch: overrun sets, sequence undisturbed
      do_reset();
      h_count = 10'd640; v_count = 10'd9;
      step();
      check("ovr flag k=1", 32'(fetch_overrun), 32'd0);
      step();
      h_count = 10'd0;
      check("ovr flag k=2", 32'(fetch_overrun), 32'd1);
      for (int k = 2; k <= 80; k++) begin
         check($sformatf("ovr mem_addr k=%0d", k), 32'(mem_addr), 32'(800 + k - 1));
         check($sformatf("ovr mem_en k=%0d", k), 32'(mem_en), 32'd1);
         step();
      end
      check("ovr end en", 32'(mem_en), 32'd0);
      step();
      check("ovr sticky", 32'(fetch_overrun), 32'd1);
      check("ovr end busy", 32'(fetch_busy), 32'd0);

      // Reset at fetch word 40 aborts the fetch and clears the flag
      do_reset();
      h_count = 10'd640; v_count = 10'd9;
      step();
      step();
      h_count = 10'd0;
      for (int k = 2; k < 41; k++) step();
      check("abort pre addr", 32'(mem_addr), 32'd840);
      check("abort pre lb_we", 32'(lb_we), 32'd1);
      check("abort pre ovr", 32'(fetch_overrun), 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("abort lb_we", 32'(lb_we), 32'd0);
      check("abort ovr", 32'(fetch_overrun), 32'd0);
      check("abort mem_en", 32'(mem_en), 32'd0);
      check("abort busy", 32'(fetch_busy), 32'd0);
      step();
      check("abort after en", 32'(mem_en), 32'd0);
      check("abort after lb_we", 32'(lb_we), 32'd0);

`ifdef VGA_FB_SCROLL_EN
      // Scroll 470 from line 20 wraps to line 10; bank follows next_line
      do_reset();
      scroll_y = 10'd470;
      run_fetch(10'd19, 800, 1'b0, "scroll");
      scroll_y = 10'd0;
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
